// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: issues one load or store over a valid/ready port,
// holds the core in stall until the access retires and returns the extended load value.
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    load_valid,
    output logic                    access_err,
    output logic                    timeout,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_we,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [3:0]              dmem_wstrb,
    input  logic                    dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata
);
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Exactly one of read/write, a known size code, and natural alignment.
    function automatic logic req_legal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] off);
        logic ok_s;
        ok_s = 1'b0;
        case (f3)
            3'b000:  ok_s = 1'b1;
            3'b001:  ok_s = ~off[0];
            3'b010:  ok_s = (off == 2'b00);
            3'b100:  ok_s = rd;
            3'b101:  ok_s = rd & ~off[0];
            default: ok_s = 1'b0;
        endcase
        return ok_s & (rd ^ wr);
    endfunction

    function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] data);
        logic [31:0] wdata_s;
        logic [3:0]  strb_s;
        case (f3[1:0])
            2'b00: begin
                wdata_s = {4{data[7:0]}};
                strb_s  = 4'b0001 << off;
            end
            2'b01: begin
                wdata_s = {2{data[15:0]}};
                strb_s  = 4'b0011 << off;
            end
            default: begin
                wdata_s = data;
                strb_s  = 4'b1111;
            end
        endcase
        return {strb_s, wdata_s};
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh_s;
        logic [31:0] res_s;
        sh_s = rdata >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   res_s = f3[2] ? {24'h000000, sh_s[7:0]} : {{24{sh_s[7]}}, sh_s[7:0]};
            2'b01:   res_s = f3[2] ? {16'h0000, sh_s[15:0]} : {{16{sh_s[15]}}, sh_s[15:0]};
            default: res_s = rdata;
        endcase
        return res_s;
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [2:0]              f3_q, f3_d;
    logic [1:0]              off_q, off_d;
    logic                    we_q, we_d;
    logic                    req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;
    logic                    access_err_q, access_err_d;
    logic                    timeout_q, timeout_d;
    logic                    stall_s;
    logic                    legal_s;
    logic [35:0]             lanes_s;

    assign legal_s = req_legal(mem_read, mem_write, funct3[2:0], addr[1:0]);
    assign lanes_s = store_lanes(funct3[2:0], addr[1:0], store_data);

    // Next-state, request latching, timeout counting and load extraction.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        off_d        = off_q;
        we_d         = we_q;
        req_valid_d  = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        access_err_d = 1'b0;
        timeout_d    = 1'b0;
        stall_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((mem_read | mem_write) && legal_s) begin
                    f3_d        = funct3[2:0];
                    off_d       = addr[1:0];
                    we_d        = mem_write;
                    addr_d      = {addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d     = lanes_s[31:0];
                    wstrb_d     = mem_write ? lanes_s[35:32] : 4'b0000;
                    cnt_d       = '0;
                    req_valid_d = 1'b1;
                    stall_s     = 1'b1;
                    state_d     = ST_REQ;
                end else if (mem_read | mem_write) begin
                    access_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                // A handshake on the last allowed cycle still completes normally.
                if (dmem_req_ready) begin
                    state_d = we_q ? ST_DONE : ST_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d   = 1'b1;
                    load_data_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                if (dmem_resp_valid) begin
                    load_data_d  = load_extract(f3_q, off_q, dmem_rdata);
                    load_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d   = 1'b1;
                    load_data_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            we_q         <= 1'b0;
            req_valid_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= 4'b0000;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            we_q         <= we_d;
            req_valid_q  <= req_valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            access_err_q <= access_err_d;
            timeout_q    <= timeout_d;
        end
    end

    // Stall covers the detect cycle, so it cannot be registered; reset masks it.
    assign stall          = stall_s & ~rst;
    assign load_data      = load_data_q;
    assign load_valid     = load_valid_q;
    assign access_err     = access_err_q;
    assign timeout        = timeout_q;
    assign dmem_req_valid = req_valid_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;

endmodule
